// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller:
// FSM state encoding, opcode field values, response selection and the
// framing byte constants, plus the packet checksum helper.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_DATA      = 3'd2,
        S_CHK       = 3'd3,
        S_EXEC      = 3'd4,
        S_RD_WAIT   = 3'd5,
        S_RESP_HDR  = 3'd6,
        S_RESP_DATA = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_BAD_LO  = 2'b10,
        OP_BAD_HI  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        RESP_RD  = 2'd0,
        RESP_ACK = 2'd1,
        RESP_NAK = 2'd2
    } resp_e;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] RD_HDR_BYTE = 8'h5A;
    localparam logic [7:0] ACK_BYTE    = 8'h06;
    localparam logic [7:0] NAK_BYTE    = 8'h15;

    // Expected checksum: CMD ^ DATA for writes, CMD alone for everything else.
    function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] chk;
        if (cmd[7:6] == OP_WRITE) begin
            chk = cmd ^ data;
        end else begin
            chk = cmd;
        end
        return chk;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter. Reloads on every received byte and counts
// down while a packet is being collected; expired is high once the count
// reaches zero while running.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CLKS = 41660
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int            CW     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    // Reload on a byte strobe, otherwise count down while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= RELOAD;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (run && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = run && (cnt_r == ZERO);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Packet-level command controller: frames SYNC/CMD/[DATA]/CHK packets from
// the UART receiver, issues one register write or read, and sequences the
// response bytes into the UART transmitter.
// Optional feature macro: UART_CMD_ACK_EN (ACK for writes, NAK for errors).
module uart_cmd_ctrl #(
    parameter int FREQUENCY    = 20_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int TIMEOUT_BITS = 20,
    parameter int NUM_REGS     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       cmd_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    import uart_cmd_pkg::*;

    localparam int         TIMEOUT_CLKS = (FREQUENCY / BAUD_RATE) * TIMEOUT_BITS;
    localparam logic [4:0] NUM_REGS_W   = 5'(NUM_REGS);

`ifdef UART_CMD_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    state_e     state_r, state_d;
    resp_e      resp_r, resp_d;
    logic [7:0] cmd_r, cmd_d;
    logic [7:0] data_r, data_d;
    logic [7:0] rd_data_r, rd_data_d;
    logic       tx_start_r, tx_start_d;
    logic [7:0] tx_byte_r, tx_byte_d;
    logic       wr_en_r, wr_en_d;
    logic       rd_en_r, rd_en_d;
    logic [3:0] addr_r, addr_d;
    logic [7:0] wdata_r, wdata_d;
    logic       cmd_err_r, cmd_err_d;
    logic [7:0] err_cnt_r, err_cnt_d;
    logic       busy_r;
    logic       err_s;
    logic       expired_s;
    logic       collecting_s;
    logic       tx_free_s;

    assign collecting_s = (state_r == S_CMD) || (state_r == S_DATA) || (state_r == S_CHK);
    // tx_busy lags tx_start by one cycle, so the cycle after a start is never free.
    assign tx_free_s    = !tx_busy && !tx_start_r;

    uart_cmd_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rx_valid),
        .run     (collecting_s),
        .expired (expired_s)
    );

    // Next-state and next-output logic for packet collection, execution and response.
    always_comb begin
        state_d    = state_r;
        resp_d     = resp_r;
        cmd_d      = cmd_r;
        data_d     = data_r;
        rd_data_d  = rd_data_r;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_r;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = addr_r;
        wdata_d    = wdata_r;
        cmd_err_d  = 1'b0;
        err_cnt_d  = err_cnt_r;
        err_s      = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    cmd_d = rx_data;
                    case (op_e'(rx_data[7:6]))
                        OP_WRITE: state_d = S_DATA;
                        OP_READ:  state_d = S_CHK;
                        default:  err_s   = 1'b1;
                    endcase
                end else if (expired_s) begin
                    err_s = 1'b1;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_d  = rx_data;
                    state_d = S_CHK;
                end else if (expired_s) begin
                    err_s = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data != calc_chk(cmd_r, data_r)) begin
                        err_s = 1'b1;
                    end else if ({1'b0, cmd_r[3:0]} >= NUM_REGS_W) begin
                        err_s = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        addr_d  = cmd_r[3:0];
                        if (op_e'(cmd_r[7:6]) == OP_WRITE) begin
                            wr_en_d = 1'b1;
                            wdata_d = data_r;
                        end else begin
                            rd_en_d = 1'b1;
                        end
                    end
                end else if (expired_s) begin
                    err_s = 1'b1;
                end else begin
                    state_d = S_CHK;
                end
            end
            S_EXEC: begin
                if (op_e'(cmd_r[7:6]) == OP_WRITE) begin
                    resp_d  = RESP_ACK;
                    state_d = ACK_EN ? S_RESP_HDR : S_IDLE;
                end else begin
                    resp_d  = RESP_RD;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                rd_data_d = reg_rd_data;
                state_d   = S_RESP_HDR;
            end
            S_RESP_HDR: begin
                if (tx_free_s) begin
                    tx_start_d = 1'b1;
                    case (resp_r)
                        RESP_RD:  tx_byte_d = RD_HDR_BYTE;
                        RESP_ACK: tx_byte_d = ACK_BYTE;
                        default:  tx_byte_d = NAK_BYTE;
                    endcase
                    state_d = (resp_r == RESP_RD) ? S_RESP_DATA : S_IDLE;
                end else begin
                    state_d = S_RESP_HDR;
                end
            end
            S_RESP_DATA: begin
                if (tx_free_s) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = rd_data_r;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_RESP_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_s) begin
            cmd_err_d = 1'b1;
            err_cnt_d = (err_cnt_r == 8'hFF) ? 8'hFF : (err_cnt_r + 8'd1);
            resp_d    = RESP_NAK;
            state_d   = ACK_EN ? S_RESP_HDR : S_IDLE;
        end else begin
            cmd_err_d = 1'b0;
        end
    end

    // State and registered-output update; reset aborts any packet or response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            resp_r     <= RESP_RD;
            cmd_r      <= 8'h00;
            data_r     <= 8'h00;
            rd_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            addr_r     <= 4'h0;
            wdata_r    <= 8'h00;
            cmd_err_r  <= 1'b0;
            err_cnt_r  <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_d;
            resp_r     <= resp_d;
            cmd_r      <= cmd_d;
            data_r     <= data_d;
            rd_data_r  <= rd_data_d;
            tx_start_r <= tx_start_d;
            tx_byte_r  <= tx_byte_d;
            wr_en_r    <= wr_en_d;
            rd_en_r    <= rd_en_d;
            addr_r     <= addr_d;
            wdata_r    <= wdata_d;
            cmd_err_r  <= cmd_err_d;
            err_cnt_r  <= err_cnt_d;
            busy_r     <= (state_d != S_IDLE);
        end
    end

    assign tx_start    = tx_start_r;
    assign tx_byte     = tx_byte_r;
    assign reg_wr_en   = wr_en_r;
    assign reg_rd_en   = rd_en_r;
    assign reg_addr    = addr_r;
    assign reg_wr_data = wdata_r;
    assign cmd_err     = cmd_err_r;
    assign err_cnt     = err_cnt_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed packets from the test plan
// plus randomized packets, checked against a packet-level reference model.
module tb_uart_cmd_ctrl;

    localparam int FREQUENCY    = 1_000_000;
    localparam int BAUD_RATE    = 100_000;
    localparam int TIMEOUT_BITS = 20;
    localparam int NUM_REGS     = 8;
    localparam int TIMEOUT_CLKS = (FREQUENCY / BAUD_RATE) * TIMEOUT_BITS;

`ifdef UART_CMD_ACK_EN
    localparam bit ACK_ON = 1'b1;
`else
    localparam bit ACK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_rd_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       cmd_err;
    logic [7:0] err_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // observation state, owned by the monitor
    logic [7:0] bank [16];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         err_pulses = 0;
    logic [3:0] last_wr_addr = 4'h0;
    logic [7:0] last_wr_data = 8'h00;
    logic [3:0] last_rd_addr = 4'h0;
    logic [7:0] tx_q [$];
    int         busy_left = 0;
    bit         rd_hold = 1'b0;

    // reference model state, owned by the test sequence
    logic [7:0] model_regs [16];
    int         model_err = 0;
    int         gap_max = 4;

    uart_cmd_ctrl #(
        .FREQUENCY    (FREQUENCY),
        .BAUD_RATE    (BAUD_RATE),
        .TIMEOUT_BITS (TIMEOUT_BITS),
        .NUM_REGS     (NUM_REGS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .cmd_err     (cmd_err),
        .err_cnt     (err_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Transmitter, register bank and event monitor, all acting on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_left = 0;
            tx_busy   = 1'b0;
            rd_hold   = 1'b0;
            for (int i = 0; i < 16; i++) bank[i] = 8'(i * 17 + 3);
        end else begin
            if (tx_start) begin
                checks++;
                if (tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_start_while_busy: tx_busy=%b required 0", tx_busy);
                end
                tx_q.push_back(tx_byte);
                busy_left = $urandom_range(6, 2);
                tx_busy   = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
                tx_busy = (busy_left != 0);
            end
            if (reg_wr_en) begin
                wr_cnt++;
                last_wr_addr   = reg_addr;
                last_wr_data   = reg_wr_data;
                bank[reg_addr] = reg_wr_data;
            end
            if (reg_rd_en) begin
                rd_cnt++;
                last_rd_addr = reg_addr;
                reg_rd_data  = bank[reg_addr];
                rd_hold      = 1'b1;
            end else if (rd_hold) begin
                rd_hold = 1'b0;
            end else begin
                reg_rd_data = 8'($urandom);
            end
            if (cmd_err) err_pulses++;
        end
    end

    task automatic init_model;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'(i * 17 + 3);
        model_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx_busy === 1'b0 && tx_start === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_tx(input logic [7:0] exp_tx [$], input string tag);
        checks++;
        if (tx_q.size() !== exp_tx.size()) begin
            errors++;
            $display("FAIL %s_tx_count: got %0d bytes, required %0d", tag, tx_q.size(), exp_tx.size());
        end else begin
            for (int i = 0; i < exp_tx.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL %s_tx_byte%0d: got %h, required %h", tag, i, tx_q[i], exp_tx[i]);
                end
            end
        end
    endtask

    // Send one packet and compare every observable effect with the reference model.
    task automatic run_packet(input logic [7:0] cmd, input logic [7:0] data,
                              input logic [7:0] chk, input bit inject_drop);
        int         kind;
        int         wr0, rd0, ep0;
        bit         ok;
        logic [1:0] op;
        logic [3:0] addr;
        logic [2:0] exp_strb;
        logic [7:0] exp_tx [$];
        int         exp_cnt;

        op   = cmd[7:6];
        addr = cmd[3:0];
        if (op == 2'b00 && chk == (cmd ^ data) && int'(addr) < NUM_REGS) kind = 0;
        else if (op == 2'b01 && chk == cmd && int'(addr) < NUM_REGS) kind = 1;
        else kind = 2;

        tx_q.delete();
        wr0 = wr_cnt; rd0 = rd_cnt; ep0 = err_pulses;

        send_byte(8'hA5);
        send_byte(cmd);
        if (op[1]) begin
            checks++;
            if (cmd_err !== 1'b1) begin
                errors++;
                $display("FAIL bad_op_err_pulse: cmd_err=%b required 1 (cmd %h)", cmd_err, cmd);
            end
        end else begin
            if (op == 2'b00) send_byte(data);
            send_byte(chk);
            exp_strb = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
            checks++;
            if ({reg_wr_en, reg_rd_en, cmd_err} !== exp_strb) begin
                errors++;
                $display("FAIL strobe_after_chk: wr/rd/err=%b required %b (cmd %h)",
                         {reg_wr_en, reg_rd_en, cmd_err}, exp_strb, cmd);
            end
        end
        if (inject_drop) begin
            rx_valid = 1'b1;
            rx_data  = 8'hA5;
            @(negedge clk);
            rx_valid = 1'b0;
        end

        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL packet_completion: busy=%b tx_busy=%b, required idle", busy, tx_busy);
        end

        if (kind == 0) begin
            model_regs[addr] = data;
            if (ACK_ON) exp_tx.push_back(8'h06);
        end else if (kind == 1) begin
            exp_tx.push_back(8'h5A);
            exp_tx.push_back(model_regs[addr]);
        end else begin
            model_err++;
            if (ACK_ON) exp_tx.push_back(8'h15);
        end
        exp_cnt = (model_err > 255) ? 255 : model_err;

        checks++;
        if ((wr_cnt - wr0) !== ((kind == 0) ? 1 : 0) || (rd_cnt - rd0) !== ((kind == 1) ? 1 : 0)) begin
            errors++;
            $display("FAIL strobe_count: wr=%0d rd=%0d, required wr=%0d rd=%0d (cmd %h)",
                     wr_cnt - wr0, rd_cnt - rd0, (kind == 0) ? 1 : 0, (kind == 1) ? 1 : 0, cmd);
        end
        if (kind == 0) begin
            checks++;
            if (last_wr_addr !== addr || last_wr_data !== data || reg_addr !== addr || reg_wr_data !== data) begin
                errors++;
                $display("FAIL write_addr_data: addr=%h data=%h, required %h %h",
                         last_wr_addr, last_wr_data, addr, data);
            end
        end
        if (kind == 1) begin
            checks++;
            if (last_rd_addr !== addr) begin
                errors++;
                $display("FAIL read_addr: got %h, required %h", last_rd_addr, addr);
            end
        end
        checks++;
        if ((err_pulses - ep0) !== ((kind == 2) ? 1 : 0) || err_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL error_count: pulses=%0d err_cnt=%0d, required pulses=%0d err_cnt=%0d",
                     err_pulses - ep0, err_cnt, (kind == 2) ? 1 : 0, exp_cnt);
        end
        check_tx(exp_tx, "packet");
    endtask

    task automatic test_reset;
        init_model();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_start, tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, cmd_err, err_cnt, busy} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {tx_start, tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, cmd_err, err_cnt, busy});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        run_packet(8'h00, 8'h03, 8'h03, 1'b0);
    endtask

    task automatic test_read;
        run_packet(8'h05, 8'h3C, 8'h39, 1'b0);
        run_packet(8'h45, 8'h00, 8'h45, 1'b0);
    endtask

    task automatic test_bad_chk;
        run_packet(8'h02, 8'h11, 8'h00, 1'b0);
    endtask

    task automatic test_bad_addr;
        run_packet(8'h49, 8'h00, 8'h49, 1'b0);
    endtask

    task automatic test_timeout;
        int         n;
        int         ep0;
        bit         seen;
        bit         ok;
        logic [7:0] exp_tx [$];
        tx_q.delete();
        send_byte(8'hA5);
        send_byte(8'h00);
        ep0  = err_pulses;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 2 * TIMEOUT_CLKS; i++) begin
            if (cmd_err === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (!seen || n < TIMEOUT_CLKS - 2 || n > TIMEOUT_CLKS + 2) begin
            errors++;
            $display("FAIL timeout_latency: seen=%b after %0d cycles, required about %0d", seen, n, TIMEOUT_CLKS);
        end
        wait_idle(ok);
        model_err++;
        checks++;
        if (!ok || (err_pulses - ep0) !== 1 || err_cnt !== 8'(model_err)) begin
            errors++;
            $display("FAIL timeout_error: idle=%b pulses=%0d err_cnt=%0d, required 1 1 %0d",
                     ok, err_pulses - ep0, err_cnt, model_err);
        end
        if (ACK_ON) exp_tx.push_back(8'h15);
        check_tx(exp_tx, "timeout");
        run_packet(8'h03, 8'h5E, 8'h5D, 1'b0);
    endtask

    task automatic test_drop;
        run_packet(8'h42, 8'h00, 8'h42, 1'b1);
        run_packet(8'h01, 8'h77, 8'h76, 1'b0);
    endtask

    task automatic random_packet;
        int         sel;
        logic [3:0] addr;
        logic [7:0] cmd, data, chk;
        sel  = $urandom_range(4, 0);
        data = 8'($urandom);
        addr = 4'($urandom_range(NUM_REGS - 1, 0));
        case (sel)
            0: begin cmd = {2'b00, 2'($urandom), addr}; chk = cmd ^ data; end
            1: begin cmd = {2'b01, 2'($urandom), addr}; chk = cmd; end
            2: begin cmd = {2'b00, 2'($urandom), addr}; chk = cmd ^ data ^ 8'($urandom_range(255, 1)); end
            3: begin
                addr = 4'($urandom_range(15, NUM_REGS));
                cmd  = {1'b0, 1'($urandom), 2'($urandom), addr};
                chk  = cmd[6] ? cmd : (cmd ^ data);
            end
            default: begin cmd = {1'b1, 7'($urandom)}; chk = 8'($urandom); end
        endcase
        run_packet(cmd, data, chk, 1'b0);
    endtask

    task automatic test_random;
        gap_max = 4;
        for (int i = 0; i < 40; i++) random_packet();
    endtask

    task automatic test_back_to_back;
        gap_max = 0;
        for (int i = 0; i < 12; i++) random_packet();
        gap_max = 4;
    endtask

    task automatic test_reset_mid;
        int wr0;
        bit ok;
        send_byte(8'hA5);
        send_byte(8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_start, tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, cmd_err, err_cnt, busy} !== 33'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h, required 0",
                     {tx_start, tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, cmd_err, err_cnt, busy});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        init_model();
        @(negedge clk);
        wr0 = wr_cnt;
        send_byte(8'h03);
        send_byte(8'h03);
        wait_idle(ok);
        checks++;
        if (!ok || wr_cnt !== wr0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_abort: idle=%b writes=%0d err_cnt=%0d, required 1 0 0",
                     ok, wr_cnt - wr0, err_cnt);
        end
    endtask

    task automatic test_saturate;
        gap_max = 1;
        for (int i = 0; i < 300; i++) begin
            run_packet({1'b1, 7'($urandom)}, 8'h00, 8'h00, 1'b0);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_cnt_saturate: got %0d, required 255", err_cnt);
        end
        gap_max = 4;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_chk();
        test_bad_addr();
        test_timeout();
        test_drop();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Packet-level command controller between the UART receiver/transmitter pair and a small on-chip register bank. It collects received bytes into framed commands (sync, command, optional data, checksum), validates them, issues one register write or read, and sequences the response bytes into the UART transmitter. It sits directly above the UART RX/TX datapath in the top level and is the only master of the register bank.

## Interface
- `FREQUENCY`, 20_000_000, system clock in Hz
- `BAUD_RATE`, 9600, UART bit rate
- `TIMEOUT_BITS`, 20, inter-byte timeout in bit periods (≥ 1)
- `NUM_REGS`, 8, implemented registers (1..16); addresses ≥ NUM_REGS are invalid

- `clk` in 1, system clock
- `reset_n` in 1, asynchronous, active-low reset
- `rx_valid` in 1, one-cycle strobe per received byte
- `rx_data` in 8, received byte, valid with `rx_valid`
- `tx_busy` in 1, transmitter busy; high from the cycle after `tx_start` until the byte completes
- `tx_start` out 1, one-cycle request to send `tx_byte`
- `tx_byte` out 8, byte to transmit, stable while `tx_start` is high
- `reg_wr_en` out 1, one-cycle register write strobe
- `reg_rd_en` out 1, one-cycle register read strobe
- `reg_addr` out 4, register address
- `reg_wr_data` out 8, write data
- `reg_rd_data` in 8, read data, valid the cycle after `reg_rd_en`
- `cmd_err` out 1, one-cycle pulse per rejected packet
- `err_cnt` out 8, saturating count of rejected packets
- `busy` out 1, high whenever state ≠ S_IDLE

## Operation
- Packet: SYNC=0xA5, CMD, [DATA], CHK. CMD[7:6]: 00=write (DATA present), 01=read (no DATA), 1x=invalid. CMD[3:0]=address. CMD[5:4] ignored.
- CHK = CMD ^ DATA (write) or CMD (read).
- States: S_IDLE, S_CMD, S_DATA, S_CHK, S_EXEC, S_RD_WAIT, S_RESP_HDR, S_RESP_DATA.
- S_IDLE: `rx_valid` with 0xA5 → S_CMD; any other byte is discarded silently.
- S_CMD: latch CMD; op 00 → S_DATA, op 01 → S_CHK, op 1x → error.
- S_DATA: latch DATA → S_CHK.
- S_CHK: mismatch → error. Address ≥ NUM_REGS → error. Otherwise → S_EXEC.
- S_EXEC (one cycle): write asserts `reg_wr_en`, read asserts `reg_rd_en`. Write → S_RESP_HDR; read → S_RD_WAIT.
- S_RD_WAIT: capture `reg_rd_data` → S_RESP_HDR.
- S_RESP_HDR: when `tx_busy`=0, pulse `tx_start`. The byte is 0x5A for a read, 0x06 (ACK) for a write, and 0x15 (NAK) for an error. The cycle after `tx_start`, `tx_busy` is ignored. Read → S_RESP_DATA; otherwise → S_IDLE.
- S_RESP_DATA: when `tx_busy`=0, send the captured read byte → S_IDLE.
- Error: pulse `cmd_err`, increment `err_cnt` (saturates at 255). If responses are enabled → S_RESP_HDR with NAK; otherwise → S_IDLE.
- Timeout: counter TIMEOUT_CLKS = (FREQUENCY/BAUD_RATE)*TIMEOUT_BITS. It runs in S_CMD/S_DATA/S_CHK and reloads on every `rx_valid`. Expiry is treated as an error.
- `rx_valid` in S_EXEC, S_RD_WAIT or response states: byte dropped, no error.

## Timing
- Reset values: all outputs 0, `err_cnt`=0, state S_IDLE. Deassertion is synchronous to `clk`.
- Reset mid-packet or mid-response: immediate abort. No register strobe is issued after `reset_n` falls.
- All outputs are registered.
- CHK `rx_valid` at cycle T → `reg_wr_en`/`reg_rd_en` high in T+1 → read data captured at T+2.
- Write `tx_start` no earlier than T+2; read header no earlier than T+3, provided `tx_busy`=0.
- `reg_addr`/`reg_wr_data` are held from S_EXEC until the next packet's S_EXEC.
- Simultaneous timeout expiry and `rx_valid`: `rx_valid` wins (byte accepted, counter reloaded).

## Configuration
- `UART_CMD_ACK_EN` defined: writes answered with ACK 0x06, errors answered with NAK 0x15.
- Not defined: writes and errors send nothing and return to S_IDLE after S_EXEC or the error; read responses (0x5A + data) are always sent; `cmd_err`/`err_cnt` are unaffected.

## Structure
- Shared package `uart_cmd_pkg`: state enum, SYNC/RD_HDR/ACK/NAK byte constants, op-code enum.
- One sub-module `uart_cmd_timeout`: loadable down-counter with reload and expiry outputs, parameterized by TIMEOUT_CLKS.

## Test plan
- Write A5 00 03 03 (addr 0, data 0x03) → `reg_wr_en` one cycle with addr 0, data 0x03; ACK 0x06 sent (macro on); nothing sent (macro off).
- Read A5 45 45 (addr 5), `reg_rd_data`=0x3C → `reg_rd_en` one cycle, then `tx_byte` 0x5A then 0x3C; each `tx_start` only while `tx_busy`=0.
- Bad checksum A5 02 11 00 → no `reg_wr_en`; `cmd_err` pulse; `err_cnt` 0→1; NAK 0x15 (macro on).
- Address 9 with NUM_REGS=8, A5 49 49 → rejected as error; no strobe.
- A5 00, then idle beyond TIMEOUT_BITS bit periods → `cmd_err`, return to S_IDLE; a following valid write completes normally.
- `reset_n` low during S_DATA → all outputs 0 and no write; 300 bad packets → `err_cnt` holds at 255.
